// File: rtl/serial_subtractor_pkg.sv
// Shared types and sizing helpers for the chunked serial subtractor.
// Holds the FSM state encoding and counter-width arithmetic.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/chunk_subtractor.sv
// Combinational CHUNK-bit subtractor built from a ripple
// of 1-bit full-subtractor cells.
module chunk_subtractor #(
  parameter int CHUNK = 1
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             bi,
  output logic [CHUNK-1:0] d,
  output logic             bo
);

  logic [CHUNK:0] bw;

  assign bw[0] = bi;

  for (genvar i = 0; i < CHUNK; i++) begin : g_cell
    assign d[i]    = x[i] ^ y[i] ^ bw[i];
    assign bw[i+1] = (~x[i] & (y[i] ^ bw[i])) | (y[i] & bw[i]);
  end

  assign bo = bw[CHUNK];

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle a - b - bin, CHUNK bits per clock, LSB chunk first,
// with borrow, zero and signed-overflow flags and start/done handshake.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int CW     = cnt_width(NCHUNK);

  if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH
      || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("serial_subtractor: illegal WIDTH/CHUNK");
  end

  state_t                 state;
  state_t                 state_nx;
  logic [CW-1:0]          cnt;
  logic [WIDTH-1:0]       a_sr;
  logic [WIDTH-1:0]       b_sr;
  logic                   brw;
  logic                   a_msb;
  logic                   b_msb;
  logic [CHUNK-1:0]       d;
  logic                   bo;
  logic [WIDTH+CHUNK-1:0] cat;
  logic [WIDTH-1:0]       diff_nx;
  logic                   take;
  logic                   last;

  chunk_subtractor #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .x  (a_sr[CHUNK-1:0]),
    .y  (b_sr[CHUNK-1:0]),
    .bi (brw),
    .d  (d),
    .bo (bo)
  );

  // New chunk enters at the MSB end; after NCHUNK shifts diff is aligned.
  always_comb begin
    cat     = {d, diff};
    diff_nx = cat[WIDTH+CHUNK-1:CHUNK];
  end

  assign take = start && (state == IDLE || state == DONE);
  assign last = (cnt == CW'(NCHUNK - 1));
  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      a_sr  <= '0;
      b_sr  <= '0;
      brw   <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      zero  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      if (take) begin
        a_sr  <= a;
        b_sr  <= b;
        brw   <= bin;
        cnt   <= '0;
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
      end else if (state == RUN) begin
        a_sr <= a_sr >> CHUNK;
        b_sr <= b_sr >> CHUNK;
        brw  <= bo;
        cnt  <= cnt + CW'(1);
        diff <= diff_nx;
        if (last) begin
          bout <= bo;
          zero <= (diff_nx == '0);
          ovf  <= (a_msb != b_msb) && (diff_nx[WIDTH-1] != a_msb);
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: three configurations
// (8/1, 8/4, 4/1) sharing clock, reset and operand buses.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       start_v [3];
  logic       busy_v  [3];
  logic       done_v  [3];
  logic [7:0] diff8;
  logic [7:0] diff84;
  logic [3:0] diff4;
  logic       bout_v  [3];
  logic       zero_v  [3];
  logic       ovf_v   [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8), .CHUNK(1)) u_w8c1 (
    .clk   (clk),
    .reset (reset),
    .start (start_v[0]),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy_v[0]),
    .done  (done_v[0]),
    .diff  (diff8),
    .bout  (bout_v[0]),
    .zero  (zero_v[0]),
    .ovf   (ovf_v[0])
  );

  serial_subtractor #(.WIDTH(8), .CHUNK(4)) u_w8c4 (
    .clk   (clk),
    .reset (reset),
    .start (start_v[1]),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy_v[1]),
    .done  (done_v[1]),
    .diff  (diff84),
    .bout  (bout_v[1]),
    .zero  (zero_v[1]),
    .ovf   (ovf_v[1])
  );

  serial_subtractor #(.WIDTH(4), .CHUNK(1)) u_w4c1 (
    .clk   (clk),
    .reset (reset),
    .start (start_v[2]),
    .a     (a[3:0]),
    .b     (b[3:0]),
    .bin   (bin),
    .busy  (busy_v[2]),
    .done  (done_v[2]),
    .diff  (diff4),
    .bout  (bout_v[2]),
    .zero  (zero_v[2]),
    .ovf   (ovf_v[2])
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(input int w, input int lat0,
                           output int lat);
    lat = lat0;
    while (!done_v[w] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      check("busy_done_excl", 32'(busy_v[w] & done_v[w]), 32'd0);
    end
  endtask

  task automatic run(input int w, input logic [7:0] x,
                     input logic [7:0] y, input logic bi,
                     output int lat);
    start_v[w] = 1'b1;
    a = x;
    b = y;
    bin = bi;
    @(posedge clk);
    #1;
    start_v[w] = 1'b0;
    check("busy_after_start", 32'(busy_v[w]), 32'd1);
    wait_done(w, 0, lat);
  endtask

  initial begin
    int lat;
    logic [4:0] ref5;
    logic [3:0] rd;
    logic       rovf;

    reset = 1'b1;
    a = '0;
    b = '0;
    bin = 1'b0;
    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    check("rst_busy", 32'(busy_v[0]), 32'd0);
    check("rst_done", 32'(done_v[0]), 32'd0);
    check("rst_diff", 32'(diff8), 32'd0);
    check("rst_bout", 32'(bout_v[0]), 32'd0);
    check("rst_zero", 32'(zero_v[0]), 32'd0);
    check("rst_ovf", 32'(ovf_v[0]), 32'd0);

    run(0, 8'h05, 8'h03, 1'b0, lat);
    check("t1_lat", 32'(lat), 32'd8);
    check("t1_diff", 32'(diff8), 32'h02);
    check("t1_bout", 32'(bout_v[0]), 32'd0);
    check("t1_zero", 32'(zero_v[0]), 32'd0);
    check("t1_ovf", 32'(ovf_v[0]), 32'd0);
    check("t1_busy", 32'(busy_v[0]), 32'd0);
    @(posedge clk);
    #1;
    check("t1_done_pulse", 32'(done_v[0]), 32'd0);
    check("t1_hold_diff", 32'(diff8), 32'h02);

    run(0, 8'h03, 8'h05, 1'b0, lat);
    check("t2_diff", 32'(diff8), 32'hFE);
    check("t2_bout", 32'(bout_v[0]), 32'd1);
    check("t2_ovf", 32'(ovf_v[0]), 32'd0);

    run(0, 8'h80, 8'h01, 1'b0, lat);
    check("t3_diff", 32'(diff8), 32'h7F);
    check("t3_bout", 32'(bout_v[0]), 32'd0);
    check("t3_ovf", 32'(ovf_v[0]), 32'd1);

    run(1, 8'h10, 8'h0F, 1'b1, lat);
    check("c4_lat", 32'(lat), 32'd2);
    check("c4_diff", 32'(diff84), 32'h00);
    check("c4_zero", 32'(zero_v[1]), 32'd1);
    check("c4_bout", 32'(bout_v[1]), 32'd0);

    // Start pulsed mid-RUN must not disturb the latched operands.
    start_v[0] = 1'b1;
    a = 8'h05;
    b = 8'h03;
    bin = 1'b0;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start_v[0] = 1'b1;
    a = 8'hAA;
    b = 8'h11;
    bin = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    wait_done(0, 4, lat);
    check("ign_lat", 32'(lat), 32'd8);
    check("ign_diff", 32'(diff8), 32'h02);
    check("ign_bout", 32'(bout_v[0]), 32'd0);

    run(0, 8'hFF, 8'hFF, 1'b1, lat);
    check("b2b_lat", 32'(lat), 32'd8);
    check("b2b_diff", 32'(diff8), 32'hFF);
    check("b2b_bout", 32'(bout_v[0]), 32'd1);
    check("b2b_ovf", 32'(ovf_v[0]), 32'd0);

    start_v[0] = 1'b1;
    a = 8'h05;
    b = 8'h03;
    bin = 1'b0;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    start_v[0] = 1'b0;
    check("mrst_busy", 32'(busy_v[0]), 32'd0);
    check("mrst_done", 32'(done_v[0]), 32'd0);
    check("mrst_diff", 32'(diff8), 32'd0);
    check("mrst_bout", 32'(bout_v[0]), 32'd0);
    check("mrst_zero", 32'(zero_v[0]), 32'd0);
    check("mrst_ovf", 32'(ovf_v[0]), 32'd0);
    @(posedge clk);
    #1;
    check("mrst_idle", 32'(busy_v[0]), 32'd0);

    run(0, 8'h20, 8'h01, 1'b0, lat);
    check("post_lat", 32'(lat), 32'd8);
    check("post_diff", 32'(diff8), 32'h1F);
    check("post_bout", 32'(bout_v[0]), 32'd0);

    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      ref5 = {1'b0, v[7:4]} - {1'b0, v[3:0]} - 5'(v[8]);
      rd = ref5[3:0];
      rovf = (v[7] != v[3]) && (rd[3] != v[7]);
      run(2, {4'h0, v[7:4]}, {4'h0, v[3:0]}, v[8], lat);
      check($sformatf("x4_bd_%0d", i),
            32'({bout_v[2], diff4}), 32'(ref5));
      check($sformatf("x4_ovf_%0d", i),
            32'(ovf_v[2]), 32'(rovf));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
